// File: rtl/simulation_top_pkg.sv
// Shared types and helpers for the multicore matrix-vector bring-up top.
// golden_result() also serves the optional SIMULATION_TOP_CHECK_EN self-checker.
package simulation_top_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int acc_width(input int data_width, input int k_len);
    return 2 * data_width + $clog2(k_len + 1);
  endfunction

  // Expected dot product of row `core` with the shared vector, operands truncated to data_width.
  function automatic longint unsigned golden_result(input int core, input int k_len,
                                                    input int data_width);
    longint unsigned sum;
    longint unsigned mask;
    longint unsigned av;
    longint unsigned bv;
    mask = (64'd1 << data_width) - 64'd1;
    sum  = 64'd0;
    for (int k = 0; k < k_len; k++) begin
      av  = 64'(core + k + 1) & mask;
      bv  = 64'(k + 1) & mask;
      sum = sum + av * bv;
    end
    return sum;
  endfunction

endpackage

// File: rtl/simulation_top_mac.sv
// Single unsigned multiply-accumulate lane; clear has priority over en.
module mac_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    r_acc;

  assign w_prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

  // Accumulator: wraps modulo 2^ACC_WIDTH.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + ACC_WIDTH'(w_prod);
    end else begin
      r_acc <= r_acc;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/simulation_top.sv
// Multicore lock-step matrix-vector top: FSM, step index, operands and result_mem.
// Optional self-check on DONE entry when SIMULATION_TOP_CHECK_EN is defined.
module simulation_top
  import simulation_top_pkg::*;
#(
  parameter int CORE_COUNT = 2,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rstN,
  input  logic startN,
  output logic processor_ready,
  output logic processDone
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, K);
  localparam int KW        = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [KW-1:0]           r_k;
  logic                    r_ready;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_a [CORE_COUNT][K];
  logic [DATA_WIDTH-1:0]   r_b [K];
  logic [ACC_WIDTH-1:0]    w_acc [CORE_COUNT];
  logic [ACC_WIDTH-1:0]    result_mem [CORE_COUNT];

  // Next-state decode; startN only matters in IDLE and DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (!startN) w_state_nxt = ST_LOAD; else w_state_nxt = ST_IDLE;
      ST_LOAD:  w_state_nxt = ST_RUN;
      ST_RUN:   if (r_k == K_LAST) w_state_nxt = ST_STORE; else w_state_nxt = ST_RUN;
      ST_STORE: w_state_nxt = ST_DONE;
      ST_DONE:  if (!startN) w_state_nxt = ST_LOAD; else w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, step index and registered status flags.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
      r_done  <= (w_state_nxt == ST_DONE);
      if (r_state == ST_LOAD) begin
        r_k <= '0;
      end else if (r_state == ST_RUN) begin
        r_k <= r_k + KW'(1);
      end else begin
        r_k <= r_k;
      end
    end
  end

  // Operand tables are fixed patterns, (re)loaded only by reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        for (int k = 0; k < K; k++) begin
          r_a[c][k] <= DATA_WIDTH'(c + k + 1);
        end
      end
      for (int k = 0; k < K; k++) begin
        r_b[k] <= DATA_WIDTH'(k + 1);
      end
    end else begin
      r_a <= r_a;
      r_b <= r_b;
    end
  end

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_core
    mac_core #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
      .clk  (clk),
      .rstN (rstN),
      .clear(r_state == ST_LOAD),
      .en   (r_state == ST_RUN),
      .a    (r_a[g][r_k]),
      .b    (r_b[r_k]),
      .acc  (w_acc[g])
    );
  end

  // Results are captured from every lane in STORE.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < CORE_COUNT; c++) result_mem[c] <= '0;
    end else if (r_state == ST_STORE) begin
      for (int c = 0; c < CORE_COUNT; c++) result_mem[c] <= w_acc[c];
    end else begin
      result_mem <= result_mem;
    end
  end

  assign processor_ready = r_ready;
  assign processDone     = r_done;

`ifdef SIMULATION_TOP_CHECK_EN
  logic r_chk_armed;

  // Flags the first cycle of each DONE visit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_chk_armed <= 1'b0;
    else       r_chk_armed <= (r_state == ST_STORE);
  end

  // Golden comparison of every lane, away from the active edge.
  always @(negedge clk) begin
    if (rstN && r_chk_armed) begin
      automatic int n_pass = 0;
      for (int c = 0; c < CORE_COUNT; c++) begin
        if (result_mem[c] == ACC_WIDTH'(golden_result(c, K, DATA_WIDTH))) begin
          n_pass++;
        end else begin
          $error("simulation_top core %0d result %0d expected %0d", c, result_mem[c],
                 ACC_WIDTH'(golden_result(c, K, DATA_WIDTH)));
        end
      end
      $display("simulation_top check: %0d of %0d cores pass", n_pass, CORE_COUNT);
    end
  end
`else
`endif

endmodule

// File: tb/tb_simulation_top.sv
// Self-checking bench: two instances (2 and 4 cores) against a cycle-count model.
module tb_simulation_top;

  localparam int K  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic startN = 1'b1;
  logic ready2, done2, ready4, done4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  simulation_top #(.CORE_COUNT(2), .K(K), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rstN(rstN), .startN(startN),
    .processor_ready(ready2), .processDone(done2)
  );

  simulation_top #(.CORE_COUNT(4), .K(K), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rstN(rstN), .startN(startN),
    .processor_ready(ready4), .processDone(done4)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Row c dotted with the shared vector, straight from the operand definitions.
  function automatic longint unsigned model_val(input int c);
    longint unsigned s = 0;
    for (int k = 0; k < K; k++) s += ((64'(c + k + 1)) & 64'hFF) * ((64'(k + 1)) & 64'hFF);
    return s;
  endfunction

  // Model: after an accepted start the block is busy for K+2 edges, then DONE with fresh results.
  int              m_cnt = 0;
  logic            m_ready = 1'b1;
  logic            m_done = 1'b0;
  longint unsigned m_res [4] = '{default: 0};

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_cnt = 0; m_ready = 1'b1; m_done = 1'b0;
      for (int c = 0; c < 4; c++) m_res[c] = 0;
    end else if (m_cnt == 0) begin
      if (!startN) begin
        m_cnt = K + 2; m_ready = 1'b0; m_done = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_ready = 1'b1; m_done = 1'b1;
        for (int c = 0; c < 4; c++) m_res[c] = model_val(c);
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    check("ready2", 64'(ready2), 64'(m_ready));
    check("done2",  64'(done2),  64'(m_done));
    check("ready4", 64'(ready4), 64'(m_ready));
    check("done4",  64'(done4),  64'(m_done));
    for (int c = 0; c < 2; c++) check("res2", 64'(u_dut.result_mem[c]), m_res[c]);
    for (int c = 0; c < 4; c++) check("res4", 64'(u_dut4.result_mem[c]), m_res[c]);
  end

  // Pulse start for one edge; optionally pulse again at busy edge `glitch`; return edges to DONE.
  task automatic run_start(input int glitch, output int lat);
    @(negedge clk); #2 startN = 1'b0;
    @(posedge clk); #1 startN = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      #1;
      if (done2) break;
      startN = (lat == glitch) ? 1'b0 : 1'b1;
    end
    startN = 1'b1;
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_ready", 64'(ready2), 64'd1);
    check("idle_done", 64'(done2), 64'd0);
    check("idle_res0", 64'(u_dut.result_mem[0]), 64'd0);

    run_start(0, lat);
    check("lat_first", 64'(lat), 64'd6);
    check("first_res0", 64'(u_dut.result_mem[0]), 64'd30);
    check("first_res1", 64'(u_dut.result_mem[1]), 64'd40);
    check("model_res1", m_res[1], 64'd40);
    check("scale_res0", 64'(u_dut4.result_mem[0]), 64'd30);
    check("scale_res1", 64'(u_dut4.result_mem[1]), 64'd40);
    check("scale_res2", 64'(u_dut4.result_mem[2]), 64'd50);
    check("scale_res3", 64'(u_dut4.result_mem[3]), 64'd60);
    repeat (3) @(posedge clk);

    run_start(0, lat);
    check("lat_restart", 64'(lat), 64'd6);
    check("restart_res0", 64'(u_dut.result_mem[0]), 64'd30);
    check("restart_res1", 64'(u_dut.result_mem[1]), 64'd40);
    repeat (2) @(posedge clk);

    run_start(3, lat);
    check("lat_busy_start", 64'(lat), 64'd6);
    repeat (4) @(posedge clk);
    #1 check("busy_done_held", 64'(done2), 64'd1);

    @(negedge clk); #2 startN = 1'b0;
    @(posedge clk); #1 startN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rstN = 1'b0;
    #1;
    check("midrst_ready", 64'(ready2), 64'd1);
    check("midrst_done", 64'(done2), 64'd0);
    check("midrst_res1", 64'(u_dut.result_mem[1]), 64'd0);
    check("midrst_res3", 64'(u_dut4.result_mem[3]), 64'd0);
    @(negedge clk); #2 rstN = 1'b1;
    run_start(0, lat);
    check("lat_after_rst", 64'(lat), 64'd6);
    check("after_rst_res0", 64'(u_dut.result_mem[0]), 64'd30);

    @(negedge clk); #2 startN = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk); #2 startN = 1'b1;
    repeat (10) @(posedge clk);

    @(negedge clk); #2 rstN = 1'b0; startN = 1'b0;
    @(negedge clk); #2 rstN = 1'b1;
    @(posedge clk); #1 startN = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      #1;
      if (done2) break;
    end
    check("lat_rst_release", 64'(lat), 64'd6);
    repeat (3) @(posedge clk);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
